mips_mem_responder: RTL

MIPS_MEM_RESPONDER -- requirements
Module: mips_mem_responder

---
 rtl/mips_mem_responder.sv | 114 +++++++++++
 1 files changed

// File: rtl/mips_mem_responder.sv
// Wait-state memory responder for a MIPS-style core: 2^ADDR_BITS x 16-bit words, one access at a time.
// Define MEM_RESPONDER_ALIGN_CHECK_EN to reject odd byte addresses and add the AlignErr output.
module mips_mem_responder #(
    parameter int WAIT_STATES = 1,
    parameter int ADDR_BITS   = 8
) (
    input  logic        clk,
    input  logic        rest,
    input  logic        IfReq,
    input  logic [15:0] IfAddress,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [15:0] DataAddress,
    input  logic [15:0] WriteData,
    output logic [15:0] MemResult,
    output logic        Ready,
    output logic        RespSrc,
    output logic        Busy
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    ,
    output logic        AlignErr
`endif
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_n;
    logic [3:0]  cnt;
    logic        is_write_q;
    logic        src_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] mem [DEPTH];

    logic                 any_req;
    logic                 accept;
    logic                 commit;
    logic                 bad_align;
    logic [ADDR_BITS-1:0] idx;
    logic [15:0]          sel_addr;
    logic                 unused_addr;

    assign any_req  = MemWrite | MemRead | IfReq;
    assign accept   = (state == IDLE) && any_req;
    assign commit   = (state == WAIT) && (cnt == WAIT_LAST);
    // Data requests outrank fetch, so the data address wins whenever either data strobe is up
    assign sel_addr = (MemWrite | MemRead) ? DataAddress : IfAddress;
    assign idx      = addr_q[ADDR_BITS:1];
    assign unused_addr = ^addr_q;

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    assign bad_align = addr_q[0];
    assign AlignErr  = Ready & addr_q[0];
`else
    assign bad_align = 1'b0;
`endif

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (any_req) state_n = WAIT;
            WAIT:    if (cnt == WAIT_LAST) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            cnt        <= '0;
            is_write_q <= 1'b0;
            src_q      <= 1'b0;
            MemResult  <= '0;
        end else begin
            if (accept) begin
                cnt        <= '0;
                is_write_q <= MemWrite;
                src_q      <= MemWrite | MemRead;
            end else if (state == WAIT) begin
                cnt <= cnt + 4'd1;
            end else begin
                cnt <= '0;
            end
            if (commit && !is_write_q && !bad_align)
                MemResult <= mem[idx];
        end
    end

    // Address and store data need no reset: they are only consumed after an accept
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= sel_addr;
            wdata_q <= WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (commit && is_write_q && !bad_align)
            mem[idx] <= wdata_q;
    end

    assign Ready   = (state == RESP);
    assign RespSrc = Ready & src_q;
    assign Busy    = (state != IDLE);

endmodule
